// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads program words over a req/ack handshake and holds them in ir.
// Optional abort-on-timeout for unanswered requests is enabled with `define FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              stall,
`ifdef FETCH_TIMEOUT_EN
    output logic              fetch_err,
`endif
    output logic              is_branch
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, REQ, DONE, ABORT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif

    state_t            state, state_n;
    logic [ADDR_W-1:0] last_addr, last_addr_n;
    logic              have_ir, have_ir_n;
    logic              gap;          // one-cycle request gap after a discarded response
    logic              ack_ok;
    logic              pc_hit;
    logic              timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] wait_cnt;
    assign timeout_hit = (state == REQ) && !gap && !mem_ack && (wait_cnt == 4'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign ack_ok = (state == REQ) && !gap && mem_ack;
    assign pc_hit = (pc_addr == mem_addr);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (enable)
            state <= state_n;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                if (ack_ok && pc_hit)
                    state_n = DONE;
                else if (timeout_hit)
                    state_n = state_t'(2'd3);
            end
            DONE: if (pc_addr != last_addr) state_n = REQ;
            default: state_n = DONE;
        endcase
    end

    always_comb begin
        mem_req   = (state == REQ) && !gap;
        is_branch = (ir[DATA_W-1 -: 12] >= 12'h800) && (ir[DATA_W-1 -: 12] <= 12'h805);
    end

    // Next-cycle view of the held address so stall settles together with ir.
    always_comb begin
        last_addr_n = last_addr;
        have_ir_n   = have_ir;
        if ((ack_ok && pc_hit) || timeout_hit) begin
            last_addr_n = mem_addr;
            have_ir_n   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            ir        <= '0;
            ir_valid  <= 1'b0;
            stall     <= 1'b1;
            last_addr <= '0;
            have_ir   <= 1'b0;
            gap       <= 1'b0;
        end else if (enable) begin
            ir_valid  <= 1'b0;
            gap       <= 1'b0;
            last_addr <= last_addr_n;
            have_ir   <= have_ir_n;
            stall     <= !(have_ir_n && (pc_addr == last_addr_n));
            case (state)
                IDLE: mem_addr <= pc_addr;
                REQ: begin
                    if (ack_ok) begin
                        if (pc_hit) begin
                            ir       <= mem_rdata;
                            ir_valid <= 1'b1;
                        end else begin
                            // PC moved while the fetch was in flight: drop the word, refetch.
                            mem_addr <= pc_addr;
                            gap      <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        ir       <= '0;
                        ir_valid <= 1'b1;
                    end
                end
                DONE: if (pc_addr != last_addr) mem_addr <= pc_addr;
                default: ;
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else if (enable) begin
            if (state != REQ || ack_ok)
                wait_cnt <= '0;
            else if (!gap)
                wait_cnt <= wait_cnt + 4'd1;
            if (timeout_hit)
                fetch_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; timeout steps run when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [11:0] pc_addr;
    logic [23:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [23:0] ir;
    logic        ir_valid;
    logic        stall;
    logic        is_branch;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(12), .DATA_W(24), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pc_addr   (pc_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .stall     (stall),
`ifdef FETCH_TIMEOUT_EN
        .fetch_err (fetch_err),
`endif
        .is_branch (is_branch)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] t2_addr [5] = '{12'h010, 12'h011, 12'h012, 12'hFFF, 12'h000};
    logic [23:0] t2_data [5] = '{24'h123456, 24'h800ABC, 24'h805001, 24'h806000, 24'h7FF111};
    logic        t2_br   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int req_cnt;
        int vld_cnt;
        int stl_cnt;

        rst = 1'b1; enable = 1'b0; pc_addr = 12'h000; mem_rdata = '0; mem_ack = 1'b0;

        // Reset state
        step(); step();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_ir", ir, 0);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_stall", stall, 1);
        check("rst_is_branch", is_branch, 0);

        // 1: first fetch at 0x000 with two wait cycles
        rst = 1'b0; enable = 1'b1;
        step();
        check("t1_req_c1", mem_req, 1);
        check("t1_addr", mem_addr, 12'h000);
        step();
        check("t1_req_c2", mem_req, 1);
        mem_rdata = 24'h800010;
        step();
        check("t1_req_c3", mem_req, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("t1_ir", ir, 24'h800010);
        check("t1_ir_valid", ir_valid, 1);
        check("t1_stall", stall, 0);
        check("t1_is_branch", is_branch, 1);
        check("t1_req_done", mem_req, 0);
        step();
        check("t1_valid_pulse", ir_valid, 0);

        // 2: zero-wait fetches, including the 0xFFF -> 0x000 wrap
        for (int i = 0; i < 5; i++) begin
            pc_addr = t2_addr[i];
            step();
            check("t2_req", mem_req, 1);
            check("t2_addr", mem_addr, t2_addr[i]);
            check("t2_stall_req", stall, 1);
            mem_ack = 1'b1; mem_rdata = t2_data[i];
            step();
            mem_ack = 1'b0;
            check("t2_ir", ir, t2_data[i]);
            check("t2_ir_valid", ir_valid, 1);
            check("t2_is_branch", is_branch, t2_br[i]);
            check("t2_stall", stall, 0);
            check("t2_no_dup_req", mem_req, 0);
        end

        // 3: held PC produces no further traffic
        pc_addr = 12'h020;
        step();
        mem_ack = 1'b1; mem_rdata = 24'h000020;
        step();
        mem_ack = 1'b0;
        check("t3_ir", ir, 24'h000020);
        req_cnt = 0; vld_cnt = 0; stl_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            req_cnt += int'(mem_req);
            vld_cnt += int'(ir_valid);
            stl_cnt += int'(stall);
        end
        check("t3_req_cycles", req_cnt, 0);
        check("t3_valid_cycles", vld_cnt, 0);
        check("t3_stall_cycles", stl_cnt, 0);

        // enable low freezes the unit even though the PC moves
        enable = 1'b0; pc_addr = 12'h060;
        step(); step();
        check("en0_mem_req", mem_req, 0);
        check("en0_mem_addr", mem_addr, 12'h020);
        check("en0_stall", stall, 0);
        check("en0_ir", ir, 24'h000020);
        enable = 1'b1;
        step();
        check("en1_req", mem_req, 1);
        check("en1_addr", mem_addr, 12'h060);
        mem_ack = 1'b1; mem_rdata = 24'h0C0FFE;
        step();
        mem_ack = 1'b0;
        check("en1_ir", ir, 24'h0C0FFE);

        // 4: PC moves mid-fetch, stale word discarded
        pc_addr = 12'h030;
        step();
        check("t4_addr_030", mem_addr, 12'h030);
        pc_addr = 12'h040; mem_ack = 1'b1; mem_rdata = 24'hAAAAAA;
        step();
        mem_ack = 1'b0;
        check("t4_ir_kept", ir, 24'h0C0FFE);
        check("t4_no_valid", ir_valid, 0);
        check("t4_gap_req", mem_req, 0);
        check("t4_new_addr", mem_addr, 12'h040);
        check("t4_stall_gap", stall, 1);
        step();
        check("t4_rereq", mem_req, 1);
        check("t4_rereq_addr", mem_addr, 12'h040);
        check("t4_stall_req", stall, 1);
        mem_ack = 1'b1; mem_rdata = 24'h456789;
        step();
        mem_ack = 1'b0;
        check("t4_ir", ir, 24'h456789);
        check("t4_ir_valid", ir_valid, 1);
        check("t4_stall", stall, 0);

`ifdef FETCH_TIMEOUT_EN
        // 6: unanswered request aborts after 15 REQ cycles
        pc_addr = 12'h070;
        step();
        req_cnt = int'(mem_req);
        vld_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            req_cnt += int'(mem_req);
            vld_cnt += int'(ir_valid);
        end
        check("t6_req_cycles", req_cnt, 15);
        check("t6_no_valid", vld_cnt, 0);
        check("t6_ir_before", ir, 24'h456789);
        check("t6_err_before", fetch_err, 0);
        step();
        check("t6_abort_req", mem_req, 0);
        check("t6_abort_ir", ir, 24'h000000);
        check("t6_abort_valid", ir_valid, 1);
        check("t6_abort_err", fetch_err, 1);
        check("t6_abort_stall", stall, 0);
        step(); step();
        check("t6_err_sticky", fetch_err, 1);
        check("t6_valid_pulse", ir_valid, 0);
`endif

        // 5: reset mid-request, late ack ignored
        pc_addr = 12'h050;
        step();
        check("t5_req", mem_req, 1);
        check("t5_addr", mem_addr, 12'h050);
        rst = 1'b1; pc_addr = 12'h055;
        step();
        check("t5_rst_req", mem_req, 0);
        check("t5_rst_ir", ir, 0);
        check("t5_rst_stall", stall, 1);
        check("t5_rst_valid", ir_valid, 0);
`ifdef FETCH_TIMEOUT_EN
        check("t5_rst_err", fetch_err, 0);
`endif
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 24'hDEAD00;
        step();
        mem_ack = 1'b0;
        check("t5_late_ir", ir, 0);
        check("t5_late_valid", ir_valid, 0);
        check("t5_new_req", mem_req, 1);
        check("t5_new_addr", mem_addr, 12'h055);
        step();
        check("t5_wait_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 24'h555555;
        step();
        mem_ack = 1'b0;
        check("t5_ir", ir, 24'h555555);
        check("t5_ir_valid", ir_valid, 1);
        check("t5_stall", stall, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch unit on the consumer side of the program counter. It takes the PC address and reads 24-bit instruction words from program memory over a req/ack handshake. It presents the word as IR to the PC and decode logic, with a valid strobe and a stall flag. The stall flag gates the PC enable while a fetch is outstanding.

Parameters:
ADDR_W, 12, program address width (matches PC output)
DATA_W, 24, instruction word width (matches IR)
TIMEOUT, 15, wait-cycle limit before abort (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  fetch enable; low freezes FSM and all registers
pc_addr  input  ADDR_W  current PC value
mem_rdata  input  DATA_W  program memory read data, valid when mem_ack=1
mem_ack  input  1  memory acknowledge, single-cycle pulse
mem_req  output  1  memory read request
mem_addr  output  ADDR_W  memory read address
ir  output  DATA_W  instruction register
ir_valid  output  1  one-cycle pulse: ir was just updated
stall  output  1  high while ir does not correspond to pc_addr
is_branch  output  1  ir[23:12] is in 12'h800..12'h805 (combinational from ir)

Behaviour:
- Reset (synchronous, active-high, wins over enable): state=IDLE, mem_req=0, mem_addr=0, ir=24'h000000, ir_valid=0, stall=1, internal last_addr=0, have_ir=0.
- States: IDLE, REQ, DONE (plus ABORT with the optional feature).
- IDLE: if enable, latch mem_addr<=pc_addr, go to REQ. mem_req asserts the next cycle.
- REQ: mem_req=1 and mem_addr held stable until mem_ack is sampled high. Zero-wait ack (ack in the first REQ cycle) is legal.
  - On ack, if pc_addr==mem_addr: ir<=mem_rdata, last_addr<=mem_addr, have_ir<=1, go to DONE.
  - On ack, if pc_addr!=mem_addr (PC moved mid-fetch): discard data, ir unchanged, mem_addr<=pc_addr, stay in REQ. mem_req drops for exactly one cycle between transactions.
- DONE: ir_valid=1 for this single cycle, mem_req=0.
  - If pc_addr==last_addr: remain idle-in-DONE with ir_valid=0 on later cycles.
  - If pc_addr!=last_addr: latch mem_addr<=pc_addr, go to REQ.
- stall = !(have_ir && pc_addr==last_addr), registered. Latency: ack at cycle N → ir and ir_valid at N+1 → stall low at N+1 if pc_addr is unchanged.
- Fetch latency: minimum 3 cycles from PC change to ir_valid (DONE→REQ, REQ with ack, DONE).
- enable=0: all state and outputs hold. A pending mem_req stays asserted and a mem_ack arriving during enable=0 is ignored. Memory must keep ack asserted or re-ack, so the system drives enable low only outside REQ.
- Same address twice: no re-fetch. ir is unchanged and ir_valid does not pulse. Conditional-jump two-cycle PC holds therefore cost no memory traffic.
- Address wrap: 12'hFFF→12'h000 is treated as an ordinary address change.
- Reset during REQ: mem_req=0 on the cycle after rst is sampled. A late ack after reset is ignored (FSM is in IDLE).

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a 4-bit counter counts REQ cycles without ack. When it reaches TIMEOUT, the FSM enters ABORT for one cycle: mem_req=0, ir<=24'h000000 (NOP), ir_valid=1, have_ir=1, last_addr<=mem_addr. A sticky fetch_err output goes high and is cleared only by rst. The counter clears on every entry to REQ.
- Not defined: REQ waits indefinitely. There is no fetch_err port and no ABORT state.

Test Plan:
1. rst=1 for 2 cycles then enable=1, pc_addr=12'h000, memory returns 24'h800010 with 2 wait cycles → mem_req high for 3 cycles at addr 0; ir=24'h800010 and ir_valid pulse one cycle after ack; is_branch=1; stall falls the same cycle.
2. Zero-wait memory, pc_addr steps 0x010→0x011→0x012 every 3 cycles → three fetches with mem_addr 0x010, 0x011, 0x012; ir_valid pulses at each; no duplicate requests.
3. pc_addr held at 0x020 for 10 cycles after fetch → exactly one mem_req transaction, one ir_valid pulse, stall=0 throughout.
4. pc_addr changes 0x030→0x040 during REQ, memory acks 0x030 with 24'hAAAAAA → data discarded, ir unchanged, new request to 0x040, ir=mem[0x040], stall high until then.
5. rst asserted mid-REQ at addr 0x050, late ack next cycle → mem_req=0, ir=0, stall=1, ack ignored; the next fetch after rst release starts at the current pc_addr.
6. FETCH_TIMEOUT_EN defined, memory never acks → after 15 REQ cycles ir=24'h000000, ir_valid pulses, fetch_err=1 and stays high until rst.
